// File: rtl/akiko_pkg.sv
// Shared definitions for the Akiko chunky-to-planar block: register
// offsets (word address bits [7:1]), the batch phase type and a sizing helper.
package akiko_pkg;

  localparam logic [6:0] AKIKO_ID_OFS   = 7'h01;
  localparam logic [6:0] AKIKO_C2P_OFS  = 7'h1C;
  localparam logic [6:0] AKIKO_STAT_OFS = 7'h1E;

  typedef enum logic {
    LOAD,
    DRAIN
  } phase_e;

  // Smallest r with 2**r >= n; used to size pointers and bit indices.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/akiko_c2p_transpose.sv
// Combinational planar extractor: picks one bit-plane out of a segment of
// DW consecutive chunky pixels held in the batch buffer.
module akiko_c2p_transpose
  import akiko_pkg::*;
#(
  parameter int DW     = 16,
  parameter int PLANES = 8,
  parameter int PIXELS = 32,
  parameter int IW     = 5
) (
  input  logic [PIXELS*PLANES-1:0] buffer,
  input  logic [IW-1:0]            plane,
  input  logic [IW-1:0]            segment,
  output logic [DW-1:0]            word
);

  localparam int PPW = DW / PLANES;
  localparam int BW  = clog2(PIXELS * PLANES);

  logic [BW-1:0] bit_idx;

  // Buffer word k holds pixels k*PPW.. MSB-first; output bit DW-1-i is the
  // selected plane bit of pixel segment*DW+i.
  always_comb begin
    word    = '0;
    bit_idx = '0;
    for (int i = 0; i < DW; i++) begin
      bit_idx = BW'(((int'(segment) * DW + i) / PPW) * DW + DW
                    - (((int'(segment) * DW + i) % PPW) + 1) * PLANES
                    + int'(plane));
      word[DW-1-i] = buffer[bit_idx];
    end
  end

endmodule

// File: rtl/akiko_c2p_gen.sv
// Akiko chunky-to-planar converter: CPU writes a batch of chunky pixel words
// to the C2P register, then reads the same batch back as planar words.
// Also provides an ID register and a status/control register.
module akiko_c2p_gen
  import akiko_pkg::*;
#(
  parameter int          DW       = 16,
  parameter int          PLANES   = 8,
  parameter int          PIXELS   = 32,
  parameter logic [15:0] ID_VALUE = 16'hCAFE
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [23:1]   address_in,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  input  logic          rd,
  input  logic          sel_akiko,
  input  logic          strobe,
  output logic          overflow
);

  localparam int WORDS = PIXELS * PLANES / DW;
  localparam int RPP   = PIXELS / DW;
  localparam int PW    = clog2(WORDS + 1);
  localparam int SW    = 2 * PW + 2;
  localparam int BITS  = PIXELS * PLANES;

  logic [6:0]      ofs;
  logic            access;
  logic            full;
  logic            addr_unused;

  phase_e          phase_q, phase_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            overflow_q, overflow_d;
  logic [BITS-1:0] buf_q;
  logic            wr_en;
  logic [PW-1:0]   wr_slot;

  logic [PW-1:0]   plane_idx;
  logic [PW-1:0]   seg_idx;
  logic [DW-1:0]   planar_word;
  logic [SW-1:0]   status_word;

  assign ofs         = address_in[7:1];
  assign addr_unused = ^address_in[23:8];
  assign access      = sel_akiko && strobe;
  assign full        = (wr_ptr_q == PW'(WORDS));
  assign overflow    = overflow_q;
  assign plane_idx   = rd_ptr_q / PW'(RPP);
  assign seg_idx     = rd_ptr_q % PW'(RPP);
  assign status_word = {overflow_q, full, wr_ptr_q, rd_ptr_q};

  akiko_c2p_transpose #(
    .DW     (DW),
    .PLANES (PLANES),
    .PIXELS (PIXELS),
    .IW     (PW)
  ) u_transpose (
    .buffer  (buf_q),
    .plane   (plane_idx),
    .segment (seg_idx),
    .word    (planar_word)
  );

  // Next-state logic for phase, pointers, overflow and the buffer write port.
  always_comb begin
    phase_d    = phase_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    wr_slot    = wr_ptr_q;
    if (access) begin
      if (ofs == AKIKO_C2P_OFS) begin
        if (rd) begin
          phase_d  = DRAIN;
          rd_ptr_d = (rd_ptr_q == PW'(WORDS - 1)) ? '0 : rd_ptr_q + PW'(1);
        end else if (phase_q == DRAIN) begin
          phase_d  = LOAD;
          rd_ptr_d = '0;
          wr_en    = 1'b1;
          wr_slot  = '0;
          wr_ptr_d = PW'(1);
        end else if (full) begin
          overflow_d = 1'b1;
        end else begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + PW'(1);
        end
      end else if (ofs == AKIKO_STAT_OFS && !rd && data_in[0]) begin
        wr_ptr_d   = '0;
        rd_ptr_d   = '0;
        overflow_d = 1'b0;
      end
    end
  end

  // State and batch buffer registers; reset clears everything including data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q    <= LOAD;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      buf_q      <= '0;
    end else begin
      phase_q    <= phase_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      if (wr_en) begin
        for (int k = 0; k < WORDS; k++) begin
          if (wr_slot == PW'(k)) buf_q[k*DW +: DW] <= data_in;
        end
      end
    end
  end

  // Zero-latency read mux; drives zero unless selected and reading.
  always_comb begin
    data_out = '0;
    if (sel_akiko && rd) begin
      case (ofs)
        AKIKO_ID_OFS:   data_out[15:0]   = ID_VALUE;
        AKIKO_C2P_OFS:  data_out         = planar_word;
        AKIKO_STAT_OFS: data_out[SW-1:0] = status_word;
        default:        data_out         = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_akiko_c2p_gen.sv
// Directed self-checking bench for akiko_c2p_gen: default 16-bit/8-plane
// instance plus a 32-bit/4-plane instance for the wide-bus case.
module tb_akiko_c2p_gen;

  localparam logic [23:0] A_ID   = 24'hB80002;
  localparam logic [23:0] A_C2P  = 24'hB80038;
  localparam logic [23:0] A_STAT = 24'hB8003C;

  logic        clk;
  logic        reset;
  logic [23:1] address_in;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        rd;
  logic        sel_akiko;
  logic        strobe;
  logic        overflow;

  logic [23:1] address_in_w;
  logic [31:0] data_in_w;
  logic [31:0] data_out_w;
  logic        rd_w;
  logic        sel_akiko_w;
  logic        strobe_w;
  logic        overflow_w;

  int tests_run;
  int tests_failed;

  akiko_c2p_gen dut (
    .clk        (clk),
    .reset      (reset),
    .address_in (address_in),
    .data_in    (data_in),
    .data_out   (data_out),
    .rd         (rd),
    .sel_akiko  (sel_akiko),
    .strobe     (strobe),
    .overflow   (overflow)
  );

  akiko_c2p_gen #(.DW(32), .PLANES(4), .PIXELS(32)) dut_w (
    .clk        (clk),
    .reset      (reset),
    .address_in (address_in_w),
    .data_in    (data_in_w),
    .data_out   (data_out_w),
    .rd         (rd_w),
    .sel_akiko  (sel_akiko_w),
    .strobe     (strobe_w),
    .overflow   (overflow_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed planar words for the pixel i = i batch (16-bit, 8 planes).
  function automatic logic [15:0] exp_ramp(input int idx);
    case (idx)
      0, 1:    return 16'h5555;
      2, 3:    return 16'h3333;
      4, 5:    return 16'h0F0F;
      6, 7:    return 16'h00FF;
      8:       return 16'h0000;
      9:       return 16'hFFFF;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic bus_write(input logic [23:0] a, input logic [15:0] d);
    @(negedge clk);
    address_in = a[23:1];
    data_in    = d;
    rd         = 1'b0;
    sel_akiko  = 1'b1;
    strobe     = 1'b1;
    @(posedge clk);
    #1;
    sel_akiko  = 1'b0;
    strobe     = 1'b0;
  endtask

  task automatic bus_read(input logic [23:0] a, output logic [15:0] d);
    @(negedge clk);
    address_in = a[23:1];
    rd         = 1'b1;
    sel_akiko  = 1'b1;
    strobe     = 1'b1;
    #1;
    d = data_out;
    @(posedge clk);
    #1;
    sel_akiko  = 1'b0;
    strobe     = 1'b0;
    rd         = 1'b0;
  endtask

  task automatic write_w(input logic [23:0] a, input logic [31:0] d);
    @(negedge clk);
    address_in_w = a[23:1];
    data_in_w    = d;
    rd_w         = 1'b0;
    sel_akiko_w  = 1'b1;
    strobe_w     = 1'b1;
    @(posedge clk);
    #1;
    sel_akiko_w  = 1'b0;
    strobe_w     = 1'b0;
  endtask

  task automatic read_w(input logic [23:0] a, output logic [31:0] d);
    @(negedge clk);
    address_in_w = a[23:1];
    rd_w         = 1'b1;
    sel_akiko_w  = 1'b1;
    strobe_w     = 1'b1;
    #1;
    d = data_out_w;
    @(posedge clk);
    #1;
    sel_akiko_w  = 1'b0;
    strobe_w     = 1'b0;
    rd_w         = 1'b0;
  endtask

  task automatic load_ramp();
    for (int k = 0; k < 16; k++) begin
      logic [7:0] hi;
      logic [7:0] lo;
      hi = 8'(2 * k);
      lo = 8'(2 * k + 1);
      bus_write(A_C2P, {hi, lo});
    end
  endtask

  task automatic test_reset();
    logic [15:0] v;
    bus_read(A_ID, v);
    tests_run++;
    if (v !== 16'hCAFE) begin
      tests_failed++;
      $display("[TB] FAIL reset_id: got %h expected %h", v, 16'hCAFE);
    end
    bus_read(A_STAT, v);
    tests_run++;
    if (v !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_status: got %h expected %h", v, 16'h0000);
    end
    bus_read(A_C2P, v);
    tests_run++;
    if (v !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_c2p: got %h expected %h", v, 16'h0000);
    end
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_overflow: got %b expected 0", overflow);
    end
  endtask

  task automatic test_alternating();
    logic [15:0] v;
    bus_write(A_STAT, 16'h0001);
    for (int k = 0; k < 16; k++) bus_write(A_C2P, 16'hFF00);
    bus_read(A_STAT, v);
    tests_run++;
    if (v !== 16'h0600) begin
      tests_failed++;
      $display("[TB] FAIL alt_status_full: got %h expected %h", v, 16'h0600);
    end
    for (int k = 0; k < 16; k++) begin
      bus_read(A_C2P, v);
      tests_run++;
      if (v !== 16'hAAAA) begin
        tests_failed++;
        $display("[TB] FAIL alt_word%0d: got %h expected %h", k, v, 16'hAAAA);
      end
    end
  endtask

  task automatic test_ramp();
    logic [15:0] v;
    load_ramp();
    for (int k = 0; k < 16; k++) begin
      bus_read(A_C2P, v);
      tests_run++;
      if (v !== exp_ramp(k)) begin
        tests_failed++;
        $display("[TB] FAIL ramp_word%0d: got %h expected %h", k, v, exp_ramp(k));
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] v;
    bus_write(A_STAT, 16'h0001);
    for (int k = 0; k < 16; k++) bus_write(A_C2P, 16'hFF00);
    bus_write(A_C2P, 16'h1234);
    bus_read(A_STAT, v);
    tests_run++;
    if (v !== 16'h0E00) begin
      tests_failed++;
      $display("[TB] FAIL ovf_status: got %h expected %h", v, 16'h0E00);
    end
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL ovf_pin: got %b expected 1", overflow);
    end
    bus_write(A_ID, 16'h0001);
    bus_read(A_C2P, v);
    tests_run++;
    if (v !== 16'hAAAA) begin
      tests_failed++;
      $display("[TB] FAIL ovf_buffer_kept: got %h expected %h", v, 16'hAAAA);
    end
    bus_read(A_STAT, v);
    tests_run++;
    if (v !== 16'h0E01) begin
      tests_failed++;
      $display("[TB] FAIL ovf_sticky: got %h expected %h", v, 16'h0E01);
    end
    bus_write(A_STAT, 16'h0001);
    bus_read(A_STAT, v);
    tests_run++;
    if (v !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL ovf_cleared: got %h expected %h", v, 16'h0000);
    end
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ovf_pin_cleared: got %b expected 0", overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    load_ramp();
    for (int k = 0; k < 5; k++) begin
      bus_read(A_C2P, v);
      tests_run++;
      if (v !== exp_ramp(k)) begin
        tests_failed++;
        $display("[TB] FAIL part_word%0d: got %h expected %h", k, v, exp_ramp(k));
      end
    end
    bus_write(A_C2P, 16'hFF00);
    bus_read(A_STAT, v);
    tests_run++;
    if (v !== 16'h0020) begin
      tests_failed++;
      $display("[TB] FAIL new_batch_status: got %h expected %h", v, 16'h0020);
    end
    bus_write(A_STAT, 16'h0001);
    load_ramp();
    for (int k = 0; k < 20; k++) begin
      bus_read(A_C2P, v);
      tests_run++;
      if (v !== exp_ramp(k % 16)) begin
        tests_failed++;
        $display("[TB] FAIL wrap_word%0d: got %h expected %h", k, v, exp_ramp(k % 16));
      end
    end
    bus_read(A_STAT, v);
    tests_run++;
    if (v !== 16'h0604) begin
      tests_failed++;
      $display("[TB] FAIL wrap_status: got %h expected %h", v, 16'h0604);
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] v;
    bus_write(A_STAT, 16'h0001);
    for (int k = 0; k < 7; k++) bus_write(A_C2P, 16'hFF00);
    bus_read(A_STAT, v);
    tests_run++;
    if (v !== 16'h00E0) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset_status: got %h expected %h", v, 16'h00E0);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus_read(A_STAT, v);
    tests_run++;
    if (v !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_status: got %h expected %h", v, 16'h0000);
    end
    for (int k = 0; k < 16; k++) begin
      bus_read(A_C2P, v);
      tests_run++;
      if (v !== 16'h0000) begin
        tests_failed++;
        $display("[TB] FAIL post_reset_word%0d: got %h expected %h", k, v, 16'h0000);
      end
    end
    @(negedge clk);
    address_in = A_C2P[23:1];
    data_in    = 16'h1234;
    rd         = 1'b0;
    sel_akiko  = 1'b0;
    strobe     = 1'b1;
    @(posedge clk);
    #1;
    rd = 1'b1;
    #1;
    tests_run++;
    if (data_out !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL unselected_read: got %h expected %h", data_out, 16'h0000);
    end
    strobe = 1'b0;
    rd     = 1'b0;
    bus_read(A_STAT, v);
    tests_run++;
    if (v !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL unselected_write: got %h expected %h", v, 16'h0000);
    end
  endtask

  task automatic test_wide();
    logic [31:0] v;
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h55555555;
    exp_w[1] = 32'h33333333;
    exp_w[2] = 32'h0F0F0F0F;
    exp_w[3] = 32'h00FF00FF;
    read_w(A_ID, v);
    tests_run++;
    if (v !== 32'h0000CAFE) begin
      tests_failed++;
      $display("[TB] FAIL wide_id: got %h expected %h", v, 32'h0000CAFE);
    end
    write_w(A_C2P, 32'h01234567);
    write_w(A_C2P, 32'h89ABCDEF);
    write_w(A_C2P, 32'h01234567);
    write_w(A_C2P, 32'h89ABCDEF);
    read_w(A_STAT, v);
    tests_run++;
    if (v !== 32'h00000060) begin
      tests_failed++;
      $display("[TB] FAIL wide_status: got %h expected %h", v, 32'h00000060);
    end
    for (int k = 0; k < 4; k++) begin
      read_w(A_C2P, v);
      tests_run++;
      if (v !== exp_w[k]) begin
        tests_failed++;
        $display("[TB] FAIL wide_word%0d: got %h expected %h", k, v, exp_w[k]);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    address_in   = '0;
    data_in      = '0;
    rd           = 1'b0;
    sel_akiko    = 1'b0;
    strobe       = 1'b0;
    address_in_w = '0;
    data_in_w    = '0;
    rd_w         = 1'b0;
    sel_akiko_w  = 1'b0;
    strobe_w     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    test_reset();
    test_alternating();
    test_ramp();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    test_wide();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
